ram_param: RTL and testbench
============================

RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits, legal range 1..32.
REQ-002 Parameter ADDR_W, default 4: address width in bits; DEPTH = 2**ADDR_W words (16 at default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 res  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  access enable; sampled on rising edge.
REQ-006 we  input  1  write select when en=1; 0 = read, 1 = write.
REQ-007 address  input  ADDR_W  word address for the access.
REQ-008 data_in  input  DATA_W  write data.
REQ-009 clr  input  1  request to start a clear sweep.
REQ-010 data_out  output  DATA_W  registered read/write-back data.
REQ-011 valid  output  1  one-cycle pulse: data_out updated this cycle.
REQ-012 busy  output  1  clear sweep in progress.
REQ-013 par_err  output  1  parity mismatch on the word just read; present only with RAM_PARITY_EN.

Function
REQ-014 Storage SHALL be a DEPTH x DATA_W register array, indexed by address.
REQ-015 FSM SHALL have exactly two states: IDLE and CLEAR.
REQ-016 IDLE, en=1, we=0: data_out SHALL equal mem[address] and valid SHALL be 1 in the following cycle (1-cycle read latency).
REQ-017 IDLE, en=1, we=1: mem[address] <= data_in; data_out SHALL equal data_in (write-first) and valid SHALL be 1 in the following cycle.
REQ-018 en=0: data_out SHALL hold its previous value; valid SHALL be 0.
REQ-019 Read after write to the same address in the next cycle SHALL return the newly written value.
REQ-020 IDLE, clr=1: FSM SHALL enter CLEAR; busy SHALL be 1 from the next cycle; any en in the same cycle SHALL be dropped (clr has priority).
REQ-021 CLEAR: an ADDR_W-bit sweep counter starting at 0 SHALL write zero to one word per cycle, ascending.
REQ-022 Sweep SHALL take exactly DEPTH cycles; after writing address DEPTH-1 the FSM SHALL return to IDLE and busy SHALL drop in the next cycle; the counter SHALL wrap to 0.
REQ-023 In CLEAR, en, we, and clr SHALL be ignored; valid SHALL be 0 and data_out SHALL hold.
REQ-024 An access presented in the first cycle in which busy=0 SHALL be serviced normally.

Reset
REQ-025 res=0 SHALL immediately force: state IDLE, sweep counter 0, data_out 0, valid 0, busy 0, par_err 0.
REQ-026 Reset SHALL NOT alter array contents; reset during CLEAR SHALL abort the sweep, leaving words already cleared at 0 and all remaining words unchanged.
REQ-027 Release of res SHALL be followed by normal operation from the first rising edge with res=1.

Configuration
REQ-028 Macro RAM_PARITY_EN defined: each word SHALL store one extra even-parity bit (XOR of data_in) on write; a clear sweep writes parity 0.
REQ-029 With RAM_PARITY_EN, on a read par_err SHALL equal (stored parity != XOR of stored data), aligned with valid; par_err SHALL be 0 on writes and whenever valid=0.
REQ-030 Macro RAM_PARITY_EN undefined: no parity storage, no par_err port; all other behaviour identical.

Verification (DATA_W=8, ADDR_W=4)
REQ-031 Write 0xA5 to addr 0x1, then read addr 0x1 -> data_out=0xA5, valid=1 one cycle after the read is sampled.
REQ-032 Write 0x3C to addr 0xF, read addr 0xF next cycle -> 0x3C; read with en=0 -> data_out holds 0x3C, valid=0.
REQ-033 Fill all 16 words with 0xFF, pulse clr -> busy high exactly 16 cycles; then reading each of 0x0..0xF returns 0x00.
REQ-034 clr and en=1/we=1 (addr 0x2, data 0x77) in the same cycle -> write dropped; after sweep, addr 0x2 reads 0x00.
REQ-035 Fill with 0xFF, pulse clr, assert res=0 after 5 sweep cycles -> busy=0, data_out=0 immediately; addr 0x0..0x4 read 0x00, addr 0x5..0xF read 0xFF.
REQ-036 With RAM_PARITY_EN: write 0x01, force-flip stored parity bit, read -> par_err=1 with valid; normal read of 0x03 -> par_err=0.

Source files
------------

// File: rtl/ram_param_if.sv
// ram_param_if -- bus bundle for the ram_param single-port RAM.
// Optional RAM_PARITY_EN macro adds the par_err return signal.
// Access semantics: the master presents en/we/address/data_in and they are
// sampled on the rising edge; valid is a one-cycle pulse marking the cycle in
// which data_out carries the result of that access. There is no ready: an
// access in IDLE is always taken, an access while busy=1 is silently dropped.
interface ram_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              clr;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              busy;
    logic              state_dbg;
`ifdef RAM_PARITY_EN
    logic              par_err;

    modport master (
        output en, we, address, data_in, clr,
        input  data_out, valid, busy, state_dbg, par_err
    );
    modport slave (
        input  en, we, address, data_in, clr,
        output data_out, valid, busy, state_dbg, par_err
    );
`else
    modport master (
        output en, we, address, data_in, clr,
        input  data_out, valid, busy, state_dbg
    );
    modport slave (
        input  en, we, address, data_in, clr,
        output data_out, valid, busy, state_dbg
    );
`endif
endinterface

// File: rtl/ram_param.sv
// ram_param -- DEPTH x DATA_W register-array RAM with registered read/write-back
// data, a one-cycle valid pulse and a self-timed clear sweep.
// Optional RAM_PARITY_EN macro stores an even-parity bit per word and reports
// a mismatch on reads through par_err.
// The array itself is never reset; only control state and outputs are.
module ram_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        res,
    ram_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              access;
    logic              sweep;
    logic              sweep_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

`ifdef RAM_PARITY_EN
    logic              par_mem [DEPTH];
    logic              mem_wpar;
    logic              par_err_q, par_err_d;
`endif

    // Sweep ends on the cycle that clears the top word
    assign sweep_last = (cnt_q == {ADDR_W{1'b1}});

    // FSM state register
    always_ff @(posedge clk or negedge res) begin
        if (!res) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: clr wins over any access in IDLE; CLEAR runs DEPTH cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.clr)    state_d = CLEAR;
            CLEAR:   if (sweep_last) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // FSM outputs: an access is only taken in IDLE without a competing clr
    always_comb begin
        access = 1'b0;
        sweep  = 1'b0;
        case (state_q)
            IDLE:    access = bus.en && !bus.clr;
            CLEAR:   sweep  = 1'b1;
            default: ;
        endcase
    end

    // Sweep counter advances only while clearing; natural wrap returns it to 0
    always_comb begin
        cnt_d = cnt_q;
        if (sweep) cnt_d = cnt_q + 1'b1;
    end

    // Sweep counter register
    always_ff @(posedge clk or negedge res) begin
        if (!res) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // Output data: write-first on writes, array word on reads, hold otherwise
    always_comb begin
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        if (access) begin
            valid_d    = 1'b1;
            data_out_d = bus.we ? bus.data_in : mem[bus.address];
        end
    end

    // Output data registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    // Array write port: sweep zeroes cnt_q, otherwise an accepted write
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.address;
        mem_wdata = bus.data_in;
        if (sweep) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (access && bus.we) begin
            mem_we = 1'b1;
        end
    end

    // Storage array, deliberately without reset so contents survive res
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

`ifdef RAM_PARITY_EN
    // Parity write value and read-side mismatch flag (reads only)
    always_comb begin
        mem_wpar  = sweep ? 1'b0 : ^bus.data_in;
        par_err_d = 1'b0;
        if (access && !bus.we)
            par_err_d = (par_mem[bus.address] != ^mem[bus.address]);
    end

    // Parity bit storage, written alongside the data word
    always_ff @(posedge clk) begin
        if (mem_we) par_mem[mem_waddr] <= mem_wpar;
    end

    // Parity error register, aligned with valid
    always_ff @(posedge clk or negedge res) begin
        if (!res) par_err_q <= 1'b0;
        else      par_err_q <= par_err_d;
    end

    assign bus.par_err = par_err_q;
`endif

    assign bus.data_out  = data_out_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = (state_q == CLEAR);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param -- bench for ram_param (DATA_W=8, ADDR_W=4).
// Build with RAM_PARITY_EN defined to include the parity checks.
module tb_ram_param;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic res = 1'b0;
    int   n_err = 0;
    int   n_checks = 0;

    ram_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: plain array plus a count of pending sweep writes
    logic [DW-1:0] ref_mem [DEPTH];
    logic          ref_par [DEPTH];
    logic [DW-1:0] ref_dout;
    logic          ref_valid;
    logic          ref_perr;
    int            sweep_left;
    int            sweep_addr;

    typedef struct {
        logic          en;
        logic          we;
        logic          clr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_dout;
        logic          exp_valid;
        logic          exp_busy;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // apply one edge worth of inputs, advance the model, compare outputs
    task automatic step(input logic e, input logic w, input logic c,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.en      = e;
        bus.we      = w;
        bus.clr     = c;
        bus.address = a;
        bus.data_in = d;
        @(posedge clk);
        ref_perr = 1'b0;
        if (sweep_left > 0) begin
            ref_mem[sweep_addr] = '0;
            ref_par[sweep_addr] = 1'b0;
            sweep_addr++;
            sweep_left--;
            ref_valid = 1'b0;
        end else if (c) begin
            sweep_left = DEPTH;
            sweep_addr = 0;
            ref_valid  = 1'b0;
        end else if (e) begin
            ref_valid = 1'b1;
            if (w) begin
                ref_mem[a] = d;
                ref_par[a] = ^d;
                ref_dout   = d;
            end else begin
                ref_dout = ref_mem[a];
                ref_perr = (ref_par[a] != ^ref_mem[a]);
            end
        end else begin
            ref_valid = 1'b0;
        end
        #1;
        check("data_out", 32'(bus.data_out), 32'(ref_dout));
        check("valid", 32'(bus.valid), 32'(ref_valid));
        check("busy", 32'(bus.busy), 32'(sweep_left > 0));
`ifdef RAM_PARITY_EN
        check("par_err", 32'(bus.par_err), 32'(ref_perr));
`endif
    endtask

    // start a clear and require busy to stay high for exactly DEPTH cycles
    task automatic run_sweep(input string name, input logic e, input logic w,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        int len;
        step(e, w, 1'b1, a, d);
        check({name, "_busy_start"}, 32'(bus.busy), 32'd1);
        len = 1;
        while (bus.busy && len < 40) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)));
            if (bus.busy) len++;
        end
        check({name, "_busy_len"}, 32'(len), 32'(DEPTH));
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 4'(i), v);
    endtask

    initial begin
        ref_dout   = '0;
        ref_valid  = 1'b0;
        ref_perr   = 1'b0;
        sweep_left = 0;
        sweep_addr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 'x;
            ref_par[i] = 1'bx;
        end
        bus.en = 1'b0; bus.we = 1'b0; bus.clr = 1'b0;
        bus.address = '0; bus.data_in = '0;

        // reset state
        #12;
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        #5 res = 1'b1;

        // establish known contents (all zero)
        run_sweep("init", 1'b0, 1'b0, 4'd0, 8'd0);

        // directed vector table
        vecs[0] = '{1'b1, 1'b1, 1'b0, 4'h1, 8'hA5, 8'hA5, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 4'h1, 8'h00, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 4'hF, 8'h3C, 8'h3C, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 4'hF, 8'h00, 8'h3C, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 4'hF, 8'h00, 8'h3C, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 4'h2, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 4'h2, 8'h5A, 8'h5A, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 4'h1, 8'h00, 8'hA5, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 4'h2, 8'hFF, 8'hA5, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 4'h2, 8'h00, 8'h5A, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].en, vecs[i].we, vecs[i].clr, vecs[i].addr, vecs[i].din);
            check($sformatf("vec%0d_dout", i), 32'(bus.data_out), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d_valid", i), 32'(bus.valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
        end

        // fill with 0xFF, clear, every word reads zero
        fill(8'hFF);
        run_sweep("clr_full", 1'b0, 1'b0, 4'd0, 8'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'(i), 8'd0);
            check($sformatf("clr_rd%0d", i), 32'(bus.data_out), 32'd0);
        end

        // clr beats a same-cycle write; first idle cycle access is serviced
        fill(8'hFF);
        run_sweep("clr_prio", 1'b1, 1'b1, 4'h2, 8'h77);
        step(1'b1, 1'b0, 1'b0, 4'h2, 8'd0);
        check("clr_prio_rd2", 32'(bus.data_out), 32'd0);
        check("clr_prio_valid", 32'(bus.valid), 32'd1);

        // reset after 5 sweep cycles aborts the sweep, array keeps contents
        fill(8'hFF);
        step(1'b0, 1'b0, 1'b1, 4'd0, 8'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        #2 res = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_dout", 32'(bus.data_out), 32'd0);
        check("abort_valid", 32'(bus.valid), 32'd0);
        sweep_left = 0;
        ref_dout   = '0;
        ref_valid  = 1'b0;
        #2 res = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'(i), 8'd0);
            check($sformatf("abort_rd%0d", i), 32'(bus.data_out), (i < 5) ? 32'h00 : 32'hFF);
        end

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)));
        end
        while (sweep_left > 0) step(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

`ifdef RAM_PARITY_EN
        // corrupted parity bit is reported on read, clean word is not
        step(1'b1, 1'b1, 1'b0, 4'h4, 8'h01);
        check("par_wr_err", 32'(bus.par_err), 32'd0);
        dut.par_mem[4] = ~dut.par_mem[4];
        ref_par[4]     = ~ref_par[4];
        step(1'b1, 1'b0, 1'b0, 4'h4, 8'd0);
        check("par_flip_err", 32'(bus.par_err), 32'd1);
        check("par_flip_valid", 32'(bus.valid), 32'd1);
        step(1'b1, 1'b1, 1'b0, 4'h5, 8'h03);
        step(1'b1, 1'b0, 1'b0, 4'h5, 8'd0);
        check("par_ok_err", 32'(bus.par_err), 32'd0);
        check("par_ok_dout", 32'(bus.data_out), 32'h03);
        step(1'b0, 1'b0, 1'b0, 4'h4, 8'd0);
        check("par_idle_err", 32'(bus.par_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
